// File: rtl/record_packer.sv
// Byte-to-record packer: gathers bytes into a record with a status trailer and
// hands finished records to a single registered output stage.
module record_packer #(
    parameter int NBYTES = 6,
    localparam int RW = NBYTES*8+16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [RW-1:0] out_rec,
    input  logic          out_ready
);

    localparam logic [3:0] LAST_IDX = 4'(NBYTES-1);

    logic [NBYTES*8-1:0] buf_q, buf_d, base_buf, new_buf;
    logic [3:0]          cnt_q, cnt_d, base_cnt, fill;
    logic [1:0]          flags_q, flags_d, new_flags;
    logic                hold_q, hold_d;
    logic [7:0]          seq_q, seq_d;
    logic                out_valid_q, out_valid_d;
    logic [RW-1:0]       out_rec_q, out_rec_d;
    logic                out_free, acc, load_held, at_end, done, load_new;

    // Handshakes: a byte moves when in_valid && in_ready, a record when
    // out_valid && out_ready. in_ready depends only on state and out_ready.
    always_comb begin
        out_free  = !out_valid_q || out_ready;
        in_ready  = !hold_q || (out_valid_q && out_ready);
        acc       = in_valid && in_ready;
        load_held = hold_q && out_free;
        // A byte accepted while a held record drains starts a fresh record.
        base_buf  = hold_q ? '0 : buf_q;
        base_cnt  = hold_q ? 4'd0 : cnt_q;
        new_buf   = base_buf;
        for (int i = 0; i < NBYTES; i++) begin
            if (4'(i) == base_cnt) new_buf[i*8 +: 8] = in_data;
        end
        fill      = base_cnt + 4'd1;
        at_end    = (base_cnt == LAST_IDX);
        done      = acc && (at_end || in_last);
        new_flags = {in_last && !at_end, in_last && at_end};
        load_new  = done && out_free && !load_held;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_rec_d   = out_rec_q;
        seq_d       = seq_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        hold_d      = hold_q;

        if (load_held) begin
            out_valid_d = 1'b1;
            out_rec_d   = {buf_q, seq_q, cnt_q, 2'b00, flags_q};
            seq_d       = seq_q + 8'd1;
        end else if (load_new) begin
            out_valid_d = 1'b1;
            out_rec_d   = {new_buf, seq_q, fill, 2'b00, new_flags};
            seq_d       = seq_q + 8'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // While holding, cnt_q carries the fill count of the held record.
        if (done && !load_new) begin
            hold_d  = 1'b1;
            buf_d   = new_buf;
            cnt_d   = fill;
            flags_d = new_flags;
        end else if (done) begin
            hold_d  = 1'b0;
            buf_d   = '0;
            cnt_d   = 4'd0;
            flags_d = 2'b00;
        end else if (acc) begin
            hold_d  = 1'b0;
            buf_d   = new_buf;
            cnt_d   = fill;
            flags_d = 2'b00;
        end else if (load_held) begin
            hold_d  = 1'b0;
            buf_d   = '0;
            cnt_d   = 4'd0;
            flags_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            cnt_q       <= 4'd0;
            flags_q     <= 2'b00;
            hold_q      <= 1'b0;
            seq_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_rec_q   <= '0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            hold_q      <= hold_d;
            seq_q       <= seq_d;
            out_valid_q <= out_valid_d;
            out_rec_q   <= out_rec_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rec   = out_rec_q;

endmodule

// File: tb/tb_record_packer.sv
// Directed, table-driven bench for record_packer with NBYTES=6.
module tb_record_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_rec;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    record_packer #(.NBYTES(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_rec   (out_rec),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_rec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic r,
                       input logic e_ir, input logic e_ov, input logic [63:0] e_rec);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = r;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_rec = e_rec;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    localparam logic [63:0] R1 = 64'h6655_4433_2211_0060;
    localparam logic [63:0] R2 = 64'h0000_0000_BBAA_0122;
    localparam logic [63:0] R3 = 64'h0605_0403_0201_0260;
    localparam logic [63:0] R4 = 64'h0C0B_0A09_0807_0360;
    localparam logic [63:0] R5 = 64'h0000_0000_000D_0412;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Each row: inputs for one cycle, outputs expected just before its edge.
        add(1, 8'h11, 0, 1, 1, 0, 64'h0);
        add(1, 8'h22, 0, 1, 1, 0, 64'h0);
        add(1, 8'h33, 0, 1, 1, 0, 64'h0);
        add(1, 8'h44, 0, 1, 1, 0, 64'h0);
        add(1, 8'h55, 0, 1, 1, 0, 64'h0);
        add(1, 8'h66, 0, 1, 1, 0, 64'h0);
        add(1, 8'hAA, 0, 1, 1, 1, R1);
        add(1, 8'hBB, 1, 1, 1, 0, 64'h0);
        add(0, 8'h00, 0, 1, 1, 1, R2);
        add(0, 8'h00, 0, 1, 1, 0, 64'h0);
        for (int i = 1; i <= 6; i++) add(1, 8'(i), 0, 0, 1, 0, 64'h0);
        for (int i = 7; i <= 12; i++) add(1, 8'(i), 0, 0, 1, 1, R3);
        add(1, 8'h0D, 0, 0, 0, 1, R3);
        add(1, 8'h0D, 1, 1, 1, 1, R3);
        add(0, 8'h00, 0, 1, 1, 1, R4);
        add(0, 8'h00, 0, 1, 1, 1, R5);
        add(0, 8'h00, 0, 0, 1, 0, 64'h0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_rec", out_rec, 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
            #1;
            chk($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            chk($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov) chk($sformatf("row%0d_out_rec", i), out_rec, vecs[i].e_rec);
        end

        // Reset mid-record with a record parked in the output register.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("pre_reset_out_valid", 64'(out_valid), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'h0);
        chk("async_reset_out_rec", out_rec, 64'h0);
        chk("async_reset_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            drive(1'b1, 8'h41 + 8'(i), (i == 5), 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        chk("after_reset_out_valid", 64'(out_valid), 64'h1);
        chk("after_reset_exact_fit", out_rec, 64'h4645_4443_4241_0061);

        // 257 single-byte records back to back: sequence field must wrap.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j <= 257; j++) begin
            if (j != 0) @(negedge clk);
            if (j <= 256) drive(1'b1, 8'(j), 1'b1, 1'b1);
            else          drive(1'b0, 8'h00, 1'b0, 1'b1);
            #1;
            if (j > 0) begin
                logic [7:0] pb;
                pb = 8'(j - 1);
                chk($sformatf("wrap%0d_out_valid", j - 1), 64'(out_valid), 64'h1);
                chk($sformatf("wrap%0d_out_rec", j - 1), out_rec, {40'h0, pb, pb, 8'h12});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/record_packer.md
RECORD_PACKER -- requirements
Module: record_packer

Interface
REQ-001 SHALL have parameter NBYTES, default 6, number of byte elements in record array field a; legal 1..15.
REQ-002 SHALL have derived width RW = NBYTES*8+16; record layout {a[NBYTES-1:0][7:0], b[15:0]}, a[0] adjacent to b.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  byte offered.
REQ-006 SHALL have port in_data  input  8  byte payload.
REQ-007 SHALL have port in_last  input  1  byte is final of current record.
REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid&&in_ready.
REQ-009 SHALL have port out_valid  output  1  out_rec holds a complete record.
REQ-010 SHALL have port out_rec  output  RW  packed record.
REQ-011 SHALL have port out_ready  input  1  record consumed when out_valid&&out_ready.

Function
REQ-012 SHALL fill bytes in arrival order: k-th accepted byte of a record (k from 0) to a[k], i.e. out_rec bits [16+8k+7:16+8k].
REQ-013 SHALL complete a record on acceptance of byte k==NBYTES-1 or of any byte with in_last=1, whichever first.
REQ-014 SHALL zero all a[] elements not written in that record.
REQ-015 SHALL set b[15:8]=record sequence number, b[7:4]=bytes filled (1..NBYTES), b[3:2]=0, b[1]=1 iff completed by in_last with fewer than NBYTES bytes, b[0]=1 iff in_last arrived on byte NBYTES-1 (exact fit).
REQ-016 SHALL increment sequence number by 1 per record loaded into output register, wrapping 255->0.
REQ-017 SHALL hold two stages: assembly buffer (byte counter + partial record) and single output register.
REQ-018 SHALL load a completed record into output register on the completing edge when output register empty or drained that same cycle (out_ready=1); out_valid rises the cycle after the completing byte is accepted (latency 1).
REQ-019 SHALL otherwise keep the completed record in assembly buffer (hold state) and load it on the first edge where the output register is empty or drained.
REQ-020 SHALL drive in_ready=0 only while in hold state; in_ready SHALL not depend combinationally on in_valid.
REQ-021 SHALL accept a new byte on the same edge the held record moves to output (in_ready=1 when hold && out_ready && out_valid), starting a fresh record at a[0].
REQ-022 SHALL keep out_rec and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL sustain one byte per cycle and one record per NBYTES cycles with out_ready held high.
REQ-024 SHALL ignore in_data/in_last when in_valid=0 or in_ready=0.

Reset
REQ-025 SHALL, on rst_n low, immediately clear out_valid=0, out_rec=0, byte counter=0, hold=0, sequence=0; in_ready=1 after reset.
REQ-026 SHALL discard any partial or held record on reset; first record after reset carries sequence 0.
REQ-027 SHALL leave reset deassertion asynchronous-assert/synchronous-effect only; first byte accepted on first edge with rst_n high.

Verification (NBYTES=6)
REQ-028 SHALL cover: bytes 11,22,33,44,55,66, out_ready=1 -> one cycle later out_valid=1, out_rec=64'h6655_4433_2211_0060.
REQ-029 SHALL cover: next record AA,BB with in_last on BB -> out_rec=64'h0000_0000_BBAA_0122.
REQ-030 SHALL cover: out_ready=0, two full records streamed -> first held in output, second in hold, in_ready=0 after sixth byte of second; out_ready=1 for two cycles -> both delivered in order, seq 0 then 1, no byte lost.
REQ-031 SHALL cover: 257 records -> seq field wraps, record 256 shows b[15:8]=8'h00.
REQ-032 SHALL cover: 6 bytes with in_last on sixth -> b=16'h0061.
REQ-033 SHALL cover: rst_n pulsed low after 3 bytes -> out_valid=0 immediately; next 6 bytes produce seq 0 record with only new bytes.
